// File: rtl/finish_banner_rx.sv
// Watches an ASCII simulation log one byte at a time and halts once a line consisting
// exactly of "*-* All Finished *-*" (LF or CR LF terminated) is received.
module finish_banner_rx #(
  parameter int LINE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  done,
  output logic                  finished,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  crlf_seen,
  output logic                  bare_cr_err
);

  typedef enum logic [2:0] {
    ST_SOL, ST_MATCH, ST_SKIP, ST_CR_M, ST_CR_S, ST_HALT
  } state_t;

  localparam logic [159:0] BANNER     = "*-* All Finished *-*";
  localparam logic [4:0]   BANNER_LEN = 5'd20;
  localparam logic [7:0]   CH_LF      = 8'h0A;
  localparam logic [7:0]   CH_CR      = 8'h0D;

  // Entries past the banner are padding so any 5-bit index stays in range.
  logic [7:0] banner_rom [32];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rom
      if (gi < 20) begin : g_chr
        assign banner_rom[gi] = BANNER[(19-gi)*8 +: 8];
      end else begin : g_pad
        assign banner_rom[gi] = 8'h00;
      end
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [4:0]            idx_reg, idx_next;
  logic                  done_reg, finished_reg, crlf_reg, bare_reg;
  logic [LINE_CNT_W-1:0] line_count_reg;

  logic       accept;
  logic       line_end, crlf_set, bare_set, halt_set;
  logic       run_line;
  logic [4:0] p_idx;

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg      <= ST_SOL;
      idx_reg        <= '0;
      done_reg       <= 1'b0;
      finished_reg   <= 1'b0;
      crlf_reg       <= 1'b0;
      bare_reg       <= 1'b0;
      line_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= halt_set;
      if (halt_set) finished_reg <= 1'b1;
      if (crlf_set) crlf_reg <= 1'b1;
      if (bare_set) bare_reg <= 1'b1;
      if (line_end && (line_count_reg != '1))
        line_count_reg <= line_count_reg + LINE_CNT_W'(1);
    end
  end

  // Next-state logic; a bare CR re-runs the current byte as the first byte of a new line.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    line_end   = 1'b0;
    crlf_set   = 1'b0;
    bare_set   = 1'b0;
    halt_set   = 1'b0;
    run_line   = 1'b0;
    p_idx      = '0;
    if (accept) begin
      case (state_reg)
        ST_SOL, ST_MATCH: begin
          run_line = 1'b1;
          p_idx    = idx_reg;
        end
        ST_SKIP: begin
          if (in_data == CH_LF) begin
            line_end   = 1'b1;
            state_next = ST_SOL;
            idx_next   = '0;
          end else if (in_data == CH_CR) begin
            state_next = ST_CR_S;
          end
        end
        ST_CR_M, ST_CR_S: begin
          line_end = 1'b1;
          idx_next = '0;
          if (in_data == CH_LF) begin
            crlf_set = 1'b1;
            if (state_reg == ST_CR_M) begin
              state_next = ST_HALT;
              halt_set   = 1'b1;
            end else begin
              state_next = ST_SOL;
            end
          end else begin
            bare_set = 1'b1;
            run_line = 1'b1;
            p_idx    = '0;
          end
        end
        default: ;
      endcase

      if (run_line) begin
        if ((p_idx < BANNER_LEN) && (in_data == banner_rom[p_idx])) begin
          state_next = ST_MATCH;
          idx_next   = p_idx + 5'd1;
        end else if (in_data == CH_LF) begin
          line_end = 1'b1;
          idx_next = '0;
          if (p_idx == BANNER_LEN) begin
            state_next = ST_HALT;
            halt_set   = 1'b1;
          end else begin
            state_next = ST_SOL;
          end
        end else if (in_data == CH_CR) begin
          state_next = (p_idx == BANNER_LEN) ? ST_CR_M : ST_CR_S;
          idx_next   = '0;
        end else begin
          state_next = ST_SKIP;
          idx_next   = '0;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    in_ready    = ~finished_reg;
    accept      = in_valid & ~finished_reg;
    done        = done_reg;
    finished    = finished_reg;
    line_count  = line_count_reg;
    crlf_seen   = crlf_reg;
    bare_cr_err = bare_reg;
  end

endmodule

// File: tb/tb_finish_banner_rx.sv
// Directed bench for finish_banner_rx: two instances (16-bit and 2-bit line counters)
// fed the same byte stream, expected values computed by hand per scenario.
module tb_finish_banner_rx;

  logic       clk;
  logic       reset_l;
  logic       in_valid;
  logic [7:0] in_data;

  logic        in_ready, done, finished, crlf_seen, bare_cr_err;
  logic [15:0] line_count;
  logic        in_ready2, done2, finished2, crlf_seen2, bare_cr_err2;
  logic [1:0]  line_count2;

  int tests;
  int fails;
  int done_cnt;
  int base;

  string banner = "*-* All Finished *-*";

  finish_banner_rx dut (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .done(done), .finished(finished), .line_count(line_count),
    .crlf_seen(crlf_seen), .bare_cr_err(bare_cr_err)
  );

  finish_banner_rx #(.LINE_CNT_W(2)) dut2 (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .done(done2), .finished(finished2), .line_count(line_count2),
    .crlf_seen(crlf_seen2), .bare_cr_err(bare_cr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'h0A;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h0A;
  endtask

  task automatic put_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++)
      put_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h0A;
    reset_l  = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_l  = 1'b1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset_l  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h0A;
    #2;

    // Unix line ending, preceded by an ordinary line
    do_reset();
    check("rst_line_count", 32'(line_count), 0);
    check("rst_flags", {done, finished, crlf_seen, bare_cr_err}, 4'b0000);
    check("rst_in_ready", 32'(in_ready), 1);
    put_str("hello\n", 0);
    check("hello_lines", 32'(line_count), 1);
    base = done_cnt;
    put_str({banner, "\n"}, 0);
    check("unix_done_pulse", 32'(done), 1);
    check("unix_finished", 32'(finished), 1);
    check("unix_lines", 32'(line_count), 2);
    check("unix_crlf", 32'(crlf_seen), 0);
    check("unix_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("unix_done_low", 32'(done), 0);
    put_str("abc\n", 0);
    check("unix_halt_lines", 32'(line_count), 2);
    check("unix_done_count", 32'(done_cnt - base), 1);

    // DOS line ending
    do_reset();
    base = done_cnt;
    put_str({banner, "\r"}, 0);
    check("dos_no_done_on_cr", 32'(done), 0);
    put_str("\n", 0);
    check("dos_done_pulse", 32'(done), 1);
    check("dos_flags", {finished, crlf_seen, bare_cr_err}, 3'b110);
    check("dos_lines", 32'(line_count), 1);

    // Near misses never match; an empty CR LF line counts
    do_reset();
    base = done_cnt;
    put_str("\r\n", 0);
    put_str({" ", banner, "\n"}, 0);
    put_str({banner, "X\n"}, 0);
    put_str("*-* All Fin\n", 0);
    check("miss_lines", 32'(line_count), 4);
    check("miss_flags", {finished, crlf_seen, bare_cr_err}, 3'b010);
    check("miss_done_count", 32'(done_cnt - base), 0);

    // Bare CR after full banner is not a banner; the next real one is
    do_reset();
    base = done_cnt;
    put_str({banner, "\rA\n"}, 0);
    check("bare_err", 32'(bare_cr_err), 1);
    check("bare_lines", 32'(line_count), 2);
    check("bare_finished", 32'(finished), 0);
    check("bare_done_count", 32'(done_cnt - base), 0);
    put_str({banner, "\n"}, 0);
    check("bare_then_done", 32'(done), 1);
    check("bare_then_lines", 32'(line_count), 3);

    // Saturation on the 2-bit counter, then reset mid-banner
    do_reset();
    put_str("\n\n\n\n\n", 0);
    check("sat_lines_w2", 32'(line_count2), 3);
    check("sat_lines_w16", 32'(line_count), 5);
    put_str("\r\na\rb\n", 0);
    check("sat_flags", {crlf_seen, bare_cr_err}, 2'b11);
    check("sat_lines_w16b", 32'(line_count), 8);
    put_str("*-* All", 0);
    reset_l = 1'b0;
    #2;
    check("midrst_lines", {16'(line_count), 14'(0), line_count2}, 0);
    check("midrst_flags", {done, finished, crlf_seen, bare_cr_err, done2, finished2}, 6'b0);
    check("midrst_in_ready", {in_ready, in_ready2}, 2'b11);
    @(posedge clk); #1;
    reset_l = 1'b1;
    base = done_cnt;
    put_str({banner, "\n"}, 0);
    check("midrst_done", {done, done2}, 2'b11);
    check("midrst_lines_after", {16'(line_count), 14'(0), line_count2}, {16'd1, 14'd0, 2'd1});

    // Random in_valid gaps (idle data is LF, which must be ignored)
    do_reset();
    base = done_cnt;
    put_str({banner, "\r\n"}, 3);
    check("gap_flags", {finished, crlf_seen, bare_cr_err}, 3'b110);
    check("gap_lines", 32'(line_count), 1);
    put_str("zz\n\n", 2);
    check("gap_halt_lines", 32'(line_count), 1);
    check("gap_in_ready", 32'(in_ready), 0);
    check("gap_done_count", 32'(done_cnt - base), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
